// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared constants, state encoding and channel mapping for the JPEG RLE encoder
package jpeg_pkg;

  localparam logic [1:0] CHAN_Y  = 2'd0;
  localparam logic [1:0] CHAN_CB = 2'd1;
  localparam logic [1:0] CHAN_CR = 2'd2;

  localparam logic [3:0]  ZRL_RUN  = 4'd15;
  localparam logic [3:0]  ZRL_SIZE = 4'd0;
  localparam logic [10:0] ZRL_AMP  = 11'd0;
  localparam logic [3:0]  EOB_RUN  = 4'd0;
  localparam logic [3:0]  EOB_SIZE = 4'd0;
  localparam logic [10:0] EOB_AMP  = 11'd0;

  localparam int SAT_MAX = 1023;
  localparam int SAT_MIN = -1024;
  localparam int AC_MIN  = -1023;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DC   = 2'd1,
    ST_AC   = 2'd2,
    ST_EOB  = 2'd3
  } state_e;

  // Channel code 3 is folded onto luma.
  function automatic logic [1:0] chan_index(input logic [1:0] chan);
    case (chan)
      CHAN_CB: return CHAN_CB;
      CHAN_CR: return CHAN_CR;
      default: return CHAN_Y;
    endcase
  endfunction

endpackage

// File: rtl/jpeg_size_cat.sv
// rtl/jpeg_size_cat.sv - JPEG magnitude category and amplitude bits of a 12-bit signed value
module jpeg_size_cat (
  input  logic signed [11:0] val_i,
  output logic [3:0]         cat_o,
  output logic [10:0]        bits_o
);

  logic [11:0] mag;
  logic [10:0] adj;
  logic [10:0] mask;

  // Negative values are sent as v-1 truncated to cat bits (one's complement of |v|).
  always_comb begin
    mag   = val_i[11] ? 12'(-val_i) : 12'(val_i);
    cat_o = '0;
    for (int i = 0; i < 12; i++) begin
      if (mag[i]) cat_o = 4'(i + 1);
    end
    adj    = val_i[11] ? 11'(val_i - 12'sd1) : val_i[10:0];
    mask   = 11'((12'd1 << cat_o) - 12'd1);
    bits_o = adj & mask;
  end

endmodule

// File: rtl/jpeg_rle_encoder.sv
// rtl/jpeg_rle_encoder.sv - per-block DC differential and AC run-length symbol generator
module jpeg_rle_encoder
  import jpeg_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int PIXEL_COUNT = 64
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] blk_coeffs,
  input  logic [1:0]                       blk_chan,
  input  logic                             blk_valid,
  output logic                             blk_ready,
  input  logic                             dc_pred_clr,
  output logic [3:0]                       sym_run,
  output logic [3:0]                       sym_size,
  output logic [10:0]                      sym_amp,
  output logic                             sym_is_dc,
  output logic                             sym_last,
  output logic                             sym_valid,
  input  logic                             sym_ready
);

  localparam int IW = $clog2(PIXEL_COUNT);
  localparam logic [IW-1:0] LAST_IDX = IW'(PIXEL_COUNT - 1);
  localparam logic signed [DATA_WIDTH-1:0] HI_W = DATA_WIDTH'(SAT_MAX);
  localparam logic signed [DATA_WIDTH-1:0] LO_W = DATA_WIDTH'(SAT_MIN);

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [3:0]              run_q, run_d;
  logic [1:0]              chan_q;
  logic signed [10:0]      coef_q [PIXEL_COUNT];
  logic [PIXEL_COUNT-1:0]  mask_q;
  logic signed [11:0]      diff_q;
  logic signed [10:0]      pred_q [3];
  logic                    live_q;

  logic signed [10:0]      sat_w [PIXEL_COUNT];
  logic [PIXEL_COUNT-1:0]  nz_w;
  logic                    accept;
  logic                    dc_xfer;
  logic [1:0]              ch_w;
  logic signed [10:0]      pred_sel;
  logic signed [10:0]      ac_val;
  logic [PIXEL_COUNT-1:0]  rem_w;
  logic                    ac_zero;
  logic                    ac_remaining;
  logic [3:0]              dc_cat, ac_cat;
  logic [10:0]             dc_bits, ac_bits;

  for (genvar g = 0; g < PIXEL_COUNT; g++) begin : g_sat
    logic signed [DATA_WIDTH-1:0] raw;
    assign raw      = blk_coeffs[g*DATA_WIDTH +: DATA_WIDTH];
    assign sat_w[g] = (raw > HI_W) ? 11'(SAT_MAX) :
                      (raw < LO_W) ? 11'(SAT_MIN) : raw[10:0];
    assign nz_w[g]  = (sat_w[g] != 11'sd0);
  end

  assign blk_ready = live_q && (state_q == ST_IDLE);
  assign accept    = blk_valid && blk_ready;
  assign ch_w      = chan_index(blk_chan);
  // A clear arriving with the block must already apply to that block's DC difference.
  assign pred_sel  = dc_pred_clr ? 11'sd0 : pred_q[ch_w];

  assign rem_w        = mask_q >> idx_q;
  assign ac_remaining = |rem_w;
  assign ac_zero      = !mask_q[idx_q];

  always_comb begin
    ac_val = coef_q[idx_q];
    if (ac_val == 11'(SAT_MIN)) ac_val = 11'(AC_MIN);
  end

  jpeg_size_cat u_dc_cat (
    .val_i  (diff_q),
    .cat_o  (dc_cat),
    .bits_o (dc_bits)
  );

  jpeg_size_cat u_ac_cat (
    .val_i  ({ac_val[10], ac_val}),
    .cat_o  (ac_cat),
    .bits_o (ac_bits)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      run_q   <= '0;
      chan_q  <= CHAN_Y;
      mask_q  <= '0;
      diff_q  <= '0;
      live_q  <= 1'b0;
      for (int i = 0; i < PIXEL_COUNT; i++) coef_q[i] <= '0;
      for (int i = 0; i < 3; i++) pred_q[i] <= '0;
    end else begin
      live_q  <= 1'b1;
      state_q <= state_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
      if (accept) begin
        chan_q <= ch_w;
        mask_q <= nz_w;
        diff_q <= {sat_w[0][10], sat_w[0]} - {pred_sel[10], pred_sel};
        for (int i = 0; i < PIXEL_COUNT; i++) coef_q[i] <= sat_w[i];
      end
      if (dc_pred_clr) begin
        for (int i = 0; i < 3; i++) pred_q[i] <= '0;
      end
      if (dc_xfer) pred_q[chan_q] <= coef_q[0];
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    run_d     = run_q;
    dc_xfer   = 1'b0;
    sym_valid = 1'b0;
    sym_run   = '0;
    sym_size  = '0;
    sym_amp   = '0;
    sym_is_dc = 1'b0;
    sym_last  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_DC;
          idx_d   = IW'(1);
          run_d   = '0;
        end
      end
      ST_DC: begin
        sym_valid = 1'b1;
        sym_is_dc = 1'b1;
        sym_size  = dc_cat;
        sym_amp   = dc_bits;
        if (sym_ready) begin
          dc_xfer = 1'b1;
          state_d = ST_AC;
        end
      end
      ST_AC: begin
        if (ac_zero && !ac_remaining) begin
          state_d = ST_EOB;
        end else if (ac_zero && run_q == ZRL_RUN) begin
          sym_valid = 1'b1;
          sym_run   = ZRL_RUN;
          sym_size  = ZRL_SIZE;
          sym_amp   = ZRL_AMP;
          if (sym_ready) begin
            run_d = '0;
            idx_d = idx_q + IW'(1);
          end
        end else if (ac_zero) begin
          run_d = run_q + 4'd1;
          idx_d = idx_q + IW'(1);
        end else begin
          sym_valid = 1'b1;
          sym_run   = run_q;
          sym_size  = ac_cat;
          sym_amp   = ac_bits;
          sym_last  = (idx_q == LAST_IDX);
          if (sym_ready) begin
            run_d = '0;
            if (idx_q == LAST_IDX) state_d = ST_IDLE;
            else                   idx_d   = idx_q + IW'(1);
          end
        end
      end
      ST_EOB: begin
        sym_valid = 1'b1;
        sym_run   = EOB_RUN;
        sym_size  = EOB_SIZE;
        sym_amp   = EOB_AMP;
        sym_last  = 1'b1;
        if (sym_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_jpeg_rle_encoder.sv
// tb/tb_jpeg_rle_encoder.sv - directed table plus randomized blocks against a symbol-list reference model
module tb_jpeg_rle_encoder;

  typedef struct packed {
    logic [3:0]  run;
    logic [3:0]  size;
    logic [10:0] amp;
    logic        dc;
    logic        last;
  } sym_t;

  typedef struct {
    int   chan;
    int   clr;
    int   c0;
    int   ia;
    int   va;
    int   ib;
    int   vb;
    int   rmode;
    int   exp_n;
    int   exp_dc_size;
    int   exp_dc_amp;
    sym_t exp_last;
  } vec_t;

  localparam sym_t EOB_S = {4'd0, 4'd0, 11'd0, 1'b0, 1'b1};

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2047:0] blk_coeffs;
  logic [1:0]    blk_chan;
  logic          blk_valid;
  logic          blk_ready;
  logic          dc_pred_clr;
  logic [3:0]    sym_run;
  logic [3:0]    sym_size;
  logic [10:0]   sym_amp;
  logic          sym_is_dc;
  logic          sym_last;
  logic          sym_valid;
  logic          sym_ready;

  int   n_cmp = 0;
  int   n_err = 0;
  int   blk_c [64];
  int   pred_m [3];
  sym_t exp_q [$];
  vec_t vecs [13];

  jpeg_rle_encoder #(.DATA_WIDTH(32), .PIXEL_COUNT(64)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .blk_coeffs  (blk_coeffs),
    .blk_chan    (blk_chan),
    .blk_valid   (blk_valid),
    .blk_ready   (blk_ready),
    .dc_pred_clr (dc_pred_clr),
    .sym_run     (sym_run),
    .sym_size    (sym_size),
    .sym_amp     (sym_amp),
    .sym_is_dc   (sym_is_dc),
    .sym_last    (sym_last),
    .sym_valid   (sym_valid),
    .sym_ready   (sym_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int lo);
    if (v > 1023) return 1023;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int catf(input int v);
    int m = (v < 0) ? -v : v;
    int n = 0;
    while (m > 0) begin
      n++;
      m = m >> 1;
    end
    return n;
  endfunction

  function automatic int bitsf(input int v);
    if (v >= 0) return v;
    return v + (1 << catf(v)) - 1;
  endfunction

  function automatic sym_t mk(input int run, input int v, input bit dc, input bit last);
    sym_t s;
    s.run  = 4'(run);
    s.size = 4'(catf(v));
    s.amp  = 11'(bitsf(v));
    s.dc   = dc;
    s.last = last;
    return s;
  endfunction

  // Reference: symbols listed from the block contents, ZRLs flushed lazily before each nonzero.
  task automatic model_block(input int chan, input bit clr_at_dc);
    int ch = (chan == 3) ? 0 : chan;
    int d0 = sat(blk_c[0], -1024);
    int last_nz = 0;
    int zeros = 0;
    int v;
    exp_q.push_back(mk(0, d0 - pred_m[ch], 1'b1, 1'b0));
    if (clr_at_dc) pred_m = '{0, 0, 0};
    pred_m[ch] = d0;
    for (int i = 1; i < 64; i++) if (sat(blk_c[i], -1023) != 0) last_nz = i;
    for (int i = 1; i <= last_nz; i++) begin
      v = sat(blk_c[i], -1023);
      if (v == 0) zeros++;
      else begin
        while (zeros >= 16) begin
          exp_q.push_back({4'd15, 4'd0, 11'd0, 1'b0, 1'b0});
          zeros -= 16;
        end
        exp_q.push_back(mk(zeros, v, 1'b0, i == 63));
        zeros = 0;
      end
    end
    if (last_nz < 63) exp_q.push_back(EOB_S);
  endtask

  task automatic collect(input int rmode, input bit clr_at_dc,
                         output int nsym, output sym_t fs, output sym_t ls);
    int   cyc = 0;
    bit   stalled = 1'b0;
    sym_t held = '0;
    sym_t cur;
    sym_t ex;
    nsym = 0;
    fs = '0;
    ls = '0;
    while (exp_q.size() > 0 && cyc < 3000) begin
      case (rmode)
        0:       sym_ready = 1'b1;
        1:       sym_ready = cyc[0];
        default: sym_ready = 1'($urandom_range(0, 1));
      endcase
      if (clr_at_dc && cyc == 0) begin
        sym_ready   = 1'b1;
        dc_pred_clr = 1'b1;
      end else dc_pred_clr = 1'b0;
      cur = {sym_run, sym_size, sym_amp, sym_is_dc, sym_last};
      if (stalled) check("stall_hold", {sym_valid, cur}, {1'b1, held});
      stalled = 1'b0;
      if (sym_valid) begin
        if (sym_ready) begin
          ex = exp_q.pop_front();
          check($sformatf("sym%0d", nsym), cur, ex);
          if (nsym == 0) fs = cur;
          ls = cur;
          nsym++;
        end else begin
          stalled = 1'b1;
          held = cur;
        end
      end
      @(negedge clk);
      cyc++;
    end
    dc_pred_clr = 1'b0;
    sym_ready = 1'b1;
    if (exp_q.size() > 0) begin
      check("sym_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    check("idle_valid", sym_valid, 0);
    check("idle_ready", blk_ready, 1);
  endtask

  task automatic send_block(input int chan, input int clr_mode, input int rmode,
                            output int nsym, output sym_t fs, output sym_t ls);
    int wait_cyc = 0;
    if (clr_mode == 1) begin
      dc_pred_clr = 1'b1;
      @(negedge clk);
      dc_pred_clr = 1'b0;
    end
    for (int i = 0; i < 64; i++) blk_coeffs[i*32 +: 32] = blk_c[i];
    blk_chan = 2'(chan);
    while (!blk_ready && wait_cyc < 100) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("accept_wait", blk_ready, 1);
    blk_valid   = 1'b1;
    dc_pred_clr = (clr_mode == 2);
    if (clr_mode == 1 || clr_mode == 2) pred_m = '{0, 0, 0};
    model_block(chan, clr_mode == 3);
    @(negedge clk);
    blk_valid   = 1'b0;
    dc_pred_clr = 1'b0;
    blk_coeffs  = {64{$urandom}};
    check("dc_latency", sym_valid, 1);
    check("ready_busy", blk_ready, 0);
    collect(rmode, clr_mode == 3, nsym, fs, ls);
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < 64; i++) blk_c[i] = 0;
    blk_c[0]    = v.c0;
    blk_c[v.ia] = v.va;
    blk_c[v.ib] = v.vb;
  endtask

  initial begin
    int   nsym;
    int   seen;
    int   r;
    sym_t fs, ls;

    vecs[0]  = '{0, 0, 12,    1,  0,     1,  0,  0, 2, 4,  12,   EOB_S};
    vecs[1]  = '{0, 0, 5,     1,  -3,    1,  -3, 0, 3, 3,  0,    EOB_S};
    vecs[2]  = '{0, 0, 0,     20, 1,     20, 1,  0, 4, 3,  2,    EOB_S};
    vecs[3]  = '{0, 0, 0,     63, -1,    63, -1, 0, 5, 0,  0,    {4'd14, 4'd1, 11'd0, 1'b0, 1'b1}};
    vecs[4]  = '{1, 0, 5000,  1,  0,     1,  0,  0, 2, 10, 1023, EOB_S};
    vecs[5]  = '{1, 1, 5000,  1,  0,     1,  0,  0, 2, 10, 1023, EOB_S};
    vecs[6]  = '{1, 2, 5000,  1,  0,     1,  0,  0, 2, 10, 1023, EOB_S};
    vecs[7]  = '{2, 0, -5000, 1,  0,     1,  0,  0, 2, 11, 1023, EOB_S};
    vecs[8]  = '{3, 0, 0,     1,  -5000, 63, 1,  2, 6, 0,  0,    {4'd13, 4'd1, 11'd1, 1'b0, 1'b1}};
    vecs[9]  = '{2, 0, 1023,  1,  0,     1,  0,  0, 2, 11, 2047, EOB_S};
    vecs[10] = '{0, 3, 100,   1,  0,     1,  0,  0, 2, 7,  100,  EOB_S};
    vecs[11] = '{2, 0, 0,     1,  0,     1,  0,  0, 2, 0,  0,    EOB_S};
    vecs[12] = '{0, 0, 100,   1,  0,     1,  0,  0, 2, 0,  0,    EOB_S};

    reset_n     = 1'b0;
    blk_coeffs  = '0;
    blk_chan    = 2'd0;
    blk_valid   = 1'b0;
    dc_pred_clr = 1'b0;
    sym_ready   = 1'b1;
    pred_m      = '{0, 0, 0};
    #3;
    check("rst_ready", blk_ready, 0);
    check("rst_valid", sym_valid, 0);
    check("rst_fields", {sym_run, sym_size, sym_amp, sym_is_dc, sym_last}, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rel_ready_early", blk_ready, 0);
    @(negedge clk);
    check("rel_ready", blk_ready, 1);
    check("rel_valid", sym_valid, 0);

    foreach (vecs[k]) begin
      load_vec(vecs[k]);
      send_block(vecs[k].chan, vecs[k].clr, vecs[k].rmode, nsym, fs, ls);
      check($sformatf("v%0d_nsym", k), nsym, vecs[k].exp_n);
      check($sformatf("v%0d_dc_size", k), fs.size, vecs[k].exp_dc_size);
      check($sformatf("v%0d_dc_amp", k), fs.amp, vecs[k].exp_dc_amp);
      check($sformatf("v%0d_last", k), ls, vecs[k].exp_last);
    end

    // ZRL block with sym_ready toggling every cycle
    load_vec(vecs[2]);
    send_block(0, 0, 1, nsym, fs, ls);
    check("stall_nsym", nsym, 4);

    // Reset in the middle of the AC scan discards the block
    for (int i = 0; i < 64; i++) blk_c[i] = 0;
    blk_c[63] = -1;
    for (int i = 0; i < 64; i++) blk_coeffs[i*32 +: 32] = blk_c[i];
    blk_chan  = 2'd1;
    blk_valid = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_valid", sym_valid, 0);
    check("midrst_ready", blk_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    pred_m  = '{0, 0, 0};
    @(negedge clk);
    check("midrst_rel_ready", blk_ready, 1);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      if (sym_valid) seen++;
      @(negedge clk);
    end
    check("midrst_no_syms", seen, 0);

    for (int b = 0; b < 40; b++) begin
      int dense = ($urandom_range(0, 9) == 0) ? 85 : 15;
      for (int i = 0; i < 64; i++) begin
        r = $urandom_range(0, 99);
        if (r >= dense) blk_c[i] = 0;
        else if (r % 4 != 0) blk_c[i] = int'($urandom_range(0, 40)) - 20;
        else case ($urandom_range(0, 6))
          0: blk_c[i] = 5000;
          1: blk_c[i] = -5000;
          2: blk_c[i] = 1024;
          3: blk_c[i] = -1024;
          4: blk_c[i] = 1023;
          5: blk_c[i] = -1023;
          default: blk_c[i] = int'($urandom_range(0, 2000)) - 1000;
        endcase
      end
      r = $urandom_range(0, 11);
      send_block(int'($urandom_range(0, 3)), (r >= 9) ? r - 8 : 0,
                 int'($urandom_range(0, 2)), nsym, fs, ls);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
